// File: rtl/pe_booth_seq.sv
// Systolic PE with a sequential radix-4 Booth multiplier and a wide, clearable accumulator.
// Handshake: an operation is accepted on a rising edge where in_valid && in_ready; in_ready is high only in IDLE.
module pe_booth_seq #(
  parameter int REG_WIDTH = 8,
  parameter int ACC_WIDTH = 2*REG_WIDTH+8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] A,
  input  logic [REG_WIDTH-1:0] B,
  input  logic                 signed_mode,
  input  logic                 acc_clear,
  output logic [REG_WIDTH-1:0] a_out,
  output logic [REG_WIDTH-1:0] b_out,
  output logic                 fwd_valid,
  output logic [ACC_WIDTH-1:0] C,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam int N  = REG_WIDTH/2 + 1;
  localparam int XW = REG_WIDTH + 2;
  localparam int PW = 2*REG_WIDTH + 2;
  localparam int CW = $clog2(N) + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_ACC = 2'd2} state_t;

  state_t                 r_state, w_next_state;
  logic [XW-1:0]          r_a_ext;
  logic [XW:0]            r_win;
  logic [PW-1:0]          r_p;
  logic [CW-1:0]          r_cnt;
  logic                   r_signed;
  logic [REG_WIDTH-1:0]   r_a_out, r_b_out;
  logic                   r_fwd_valid, r_done;
  logic [ACC_WIDTH-1:0]   r_c;

  logic                   w_accept, w_last;
  logic [XW-1:0]          w_a_ext_in, w_b_ext_in;
  logic [PW-1:0]          w_a_wide, w_a_sh, w_a_sh2, w_term;
  logic [SW-1:0]          w_sh, w_sh1;
  logic [ACC_WIDTH-1:0]   w_prod_ext;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(N-1));

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign fwd_valid = r_fwd_valid;
  assign done      = r_done;
  assign C         = r_c;

  always_comb begin
    w_a_ext_in = {2'b00, A};
    w_b_ext_in = {2'b00, B};
    if (signed_mode) begin
      w_a_ext_in = {{2{A[REG_WIDTH-1]}}, A};
      w_b_ext_in = {{2{B[REG_WIDTH-1]}}, B};
    end
  end

  // The latched multiplicand already carries its sign in the top bit, so always sign-extend it.
  assign w_a_wide = PW'($signed(r_a_ext));
  assign w_sh     = {r_cnt, 1'b0};
  assign w_sh1    = w_sh + SW'(1);
  assign w_a_sh   = w_a_wide << w_sh;
  assign w_a_sh2  = w_a_wide << w_sh1;

  always_comb begin
    w_term = '0;
    case (r_win[2:0])
      3'b001, 3'b010: w_term = w_a_sh;
      3'b011:         w_term = w_a_sh2;
      3'b100:         w_term = -w_a_sh2;
      3'b101, 3'b110: w_term = -w_a_sh;
      default:        w_term = '0;
    endcase
  end

  always_comb begin
    w_prod_ext = ACC_WIDTH'(r_p[2*REG_WIDTH-1:0]);
    if (r_signed) w_prod_ext = ACC_WIDTH'($signed(r_p[2*REG_WIDTH-1:0]));
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_MUL;
      S_MUL:   if (w_last) w_next_state = S_ACC;
      S_ACC:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_ext     <= '0;
      r_win       <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_fwd_valid <= 1'b0;
      r_done      <= 1'b0;
      r_c         <= '0;
    end else begin
      r_fwd_valid <= 1'b0;
      r_done      <= 1'b0;
      if (acc_clear && r_state != S_ACC) r_c <= '0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a_ext     <= w_a_ext_in;
          r_win       <= {w_b_ext_in, 1'b0};
          r_signed    <= signed_mode;
          r_p         <= '0;
          r_cnt       <= '0;
          r_a_out     <= A;
          r_b_out     <= B;
          r_fwd_valid <= 1'b1;
        end
        S_MUL: begin
          r_p   <= r_p + w_term;
          r_win <= {{2{r_win[XW]}}, r_win[XW:2]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_ACC: begin
          // A coincident clear turns the accumulate into a load of the fresh product.
          r_c    <= (acc_clear ? '0 : r_c) + w_prod_ext;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_booth_seq.sv
// Bench for pe_booth_seq: an arithmetic reference model checked every cycle, plus directed literal checks.
module tb_pe_booth_seq;
  localparam int W   = 8;
  localparam int N   = W/2 + 1;
  localparam int AW0 = 2*W + 8;
  localparam int AW1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, signed_mode, acc_clear;
  logic [W-1:0] a_in, b_in;

  logic           in_ready0, fwd_valid0, busy0, done0;
  logic [W-1:0]   a_out0, b_out0;
  logic [AW0-1:0] c0;
  logic [1:0]     dbg0;
  logic           in_ready1, fwd_valid1, busy1, done1;
  logic [W-1:0]   a_out1, b_out1;
  logic [AW1-1:0] c1;
  logic [1:0]     dbg1;

  pe_booth_seq #(.REG_WIDTH(W), .ACC_WIDTH(AW0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a_in), .B(b_in), .signed_mode(signed_mode), .acc_clear(acc_clear),
    .a_out(a_out0), .b_out(b_out0), .fwd_valid(fwd_valid0), .C(c0),
    .busy(busy0), .done(done0), .dbg_state(dbg0));

  pe_booth_seq #(.REG_WIDTH(W), .ACC_WIDTH(AW1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a_in), .B(b_in), .signed_mode(signed_mode), .acc_clear(acc_clear),
    .a_out(a_out1), .b_out(b_out1), .fwd_valid(fwd_valid1), .C(c1),
    .busy(busy1), .done(done1), .dbg_state(dbg1));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an operation is a countdown plus a precomputed integer product.
  longint m_c0, m_c1, m_prod;
  int     m_left;
  logic   m_live = 1'b0;
  logic   m_fwd, m_done;
  logic [W-1:0] m_a_out, m_b_out;
  localparam longint M0 = (64'sd1 << AW0) - 1;
  localparam longint M1 = (64'sd1 << AW1) - 1;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_left = 0; m_c0 = 0; m_c1 = 0; m_prod = 0;
      m_fwd = 1'b0; m_done = 1'b0; m_a_out = '0; m_b_out = '0;
    end else if (m_live) begin
      m_fwd = 1'b0; m_done = 1'b0;
      if (m_left == 1) begin
        m_c0 = ((acc_clear ? 64'sd0 : m_c0) + m_prod) & M0;
        m_c1 = ((acc_clear ? 64'sd0 : m_c1) + m_prod) & M1;
        m_done = 1'b1;
        m_left = 0;
      end else begin
        if (acc_clear) begin m_c0 = 0; m_c1 = 0; end
        if (m_left > 0) m_left--;
        else if (in_valid) begin
          m_prod = signed_mode ? longint'($signed(a_in)) * longint'($signed(b_in))
                               : longint'(a_in) * longint'(b_in);
          m_a_out = a_in; m_b_out = b_in; m_fwd = 1'b1;
          m_left = N + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && !reset) begin
      check("in_ready", in_ready0, m_left == 0);
      check("busy", busy0, m_left != 0);
      check("state_idle", dbg0 == 2'd0, m_left == 0);
      check("fwd_valid", fwd_valid0, m_fwd);
      check("done", done0, m_done);
      check("a_out", a_out0, m_a_out);
      check("b_out", b_out0, m_b_out);
      check("c_wide", c0, m_c0);
      check("c_narrow", c1, m_c1);
      check("done_narrow", done1, m_done);
    end
    if (done0) done_cnt++;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
    int g = 0;
    while (!in_ready0 && g < 50) begin @(posedge clk); #1; g++; end
    if (!in_ready0) check("ready_timeout", 0, 1);
    in_valid = 1'b1; a_in = a; b_in = b; signed_mode = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fwd_after_accept", fwd_valid0, 1);
    check("a_out_fwd", a_out0, a);
    check("b_out_fwd", b_out0, b);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (done0) break;
    end
    check("done_seen", done0, 1);
  endtask

  task automatic clear_c();
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    check("clear_idle", c0, 0);
  endtask

  initial begin
    int lat, d0;
    reset = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; acc_clear = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_c", c0, 0);
    check("reset_ready", in_ready0, 1);
    check("reset_done", done0, 0);

    // Unsigned full-scale product and fixed latency.
    run_op(8'd255, 8'd255, 1'b0, lat);
    check("t1_latency", lat, 6);
    check("t1_c", c0, 65025);
    check("t1_c_narrow", c1, 65025);
    clear_c();

    // Signed corner and mixed-sign accumulate.
    run_op(8'h80, 8'h80, 1'b1, lat);
    check("t2_c_a", c0, 16384);
    run_op(8'd3, 8'hFB, 1'b1, lat);
    check("t2_c_b", c0, 16369);
    clear_c();

    // Same bits, different signedness.
    run_op(8'h80, 8'h02, 1'b0, lat);
    check("t3_unsigned", c0, 256);
    clear_c();
    run_op(8'h80, 8'h02, 1'b1, lat);
    check("t3_signed", c0, 24'hFFFF00);
    check("t3_signed_narrow", c1, 16'hFF00);
    clear_c();

    // Back-to-back with in_valid held high.
    d0 = done_cnt;
    in_valid = 1'b1; a_in = 8'd2; b_in = 8'd3; signed_mode = 1'b0;
    @(posedge clk); #1;
    a_in = 8'd4; b_in = 8'd5;
    check("t4_ready_e0", in_ready0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check("t4_ready", in_ready0, k == 6);
    end
    check("t4_done1", done0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_second_accept", fwd_valid0, 1);
    check("t4_a_out", a_out0, 4);
    lat = 0;
    while (lat < 20) begin @(posedge clk); #1; lat++; if (done0) break; end
    check("t4_done2", done0, 1);
    check("t4_c", c0, 26);
    @(negedge clk); #1;
    check("t4_done_count", done_cnt - d0, 2);
    clear_c();

    // Clear-and-load on the accumulate edge, then clear in idle.
    run_op(8'd2, 8'd5, 1'b0, lat);
    check("t5_c10", c0, 10);
    in_valid = 1'b1; a_in = 8'd7; b_in = 8'd7; signed_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1 acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    check("t5_done", done0, 1);
    check("t5_c49", c0, 49);
    clear_c();

    // Reset mid-multiply aborts without a done pulse.
    in_valid = 1'b1; a_in = 8'd100; b_in = 8'd100; signed_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("t6_c", c0, 0);
    check("t6_busy", busy0, 0);
    check("t6_fwd", fwd_valid0, 0);
    check("t6_a_out", a_out0, 0);
    check("t6_b_out", b_out0, 0);
    check("t6_done", done0, 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1 check("t6_no_done", done_cnt - d0, 0);
    run_op(8'd2, 8'd2, 1'b0, lat);
    check("t6_c4", c0, 4);
    clear_c();

    // Narrow accumulator wraps.
    run_op(8'd255, 8'd255, 1'b0, lat);
    run_op(8'd255, 8'd255, 1'b0, lat);
    check("t7_wrap_narrow", c1, 64514);
    check("t7_wide", c0, 130050);

    repeat (3) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_booth_seq.md
Name: pe_booth_seq

Overview:
Next-generation systolic processing element built around a sequential radix-4 Booth multiplier. It processes one recoded digit per clock and supports signed or unsigned operands, selected per operation. A valid/ready handshake gates each operation, the accumulator is wide and clearable, and accepted operands are forwarded to the east and south neighbours with a valid strobe. It drops into the same systolic array fabric as the existing combinational PE, trading latency for area.

Parameters:
REG_WIDTH, 8, operand width; must be even and >= 4.
ACC_WIDTH, 2*REG_WIDTH+8, accumulator width; must be >= 2*REG_WIDTH.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  A/B/signed_mode are presented.
in_ready  output  1  PE can accept an operation.
A  input  REG_WIDTH  multiplicand.
B  input  REG_WIDTH  multiplier (Booth-recoded).
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
acc_clear  input  1  synchronous accumulator clear.
a_out  output  REG_WIDTH  forwarded A.
b_out  output  REG_WIDTH  forwarded B.
fwd_valid  output  1  a_out/b_out updated this cycle.
C  output  ACC_WIDTH  accumulator.
busy  output  1  operation in progress (state != IDLE).
done  output  1  one-cycle pulse; C holds the newly accumulated value.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: C=0, a_out=0, b_out=0, fwd_valid=0, done=0, busy=0, state=IDLE, digit counter=0. Reset mid-operation aborts the operation, produces no done, and discards the partial product.
- Digit count N = REG_WIDTH/2+1. Operands are extended to REG_WIDTH+2 bits: sign-extended if signed_mode, zero-extended otherwise. N digits are always processed, so latency is fixed for both modes.
- in_ready = (state==IDLE). It is combinational from the state register. in_valid is ignored when in_ready=0.
- State IDLE, accept edge (in_valid & in_ready):
  - Latch the extended A and B, plus signed_mode.
  - Set the Booth window to {B_ext, 1'b0}; clear the partial product P (2*REG_WIDTH+2 bits); set the digit counter to 0.
  - a_out<=A, b_out<=B, fwd_valid<=1 for exactly one cycle.
  - Go to MUL.
- State MUL, one digit per edge. Let d = the low 3 window bits.
  - 000/111: add 0.
  - 001/010: add +A_ext<<2i.
  - 011: add +A_ext<<(2i+1).
  - 100: add -A_ext<<(2i+1).
  - 101/110: add -A_ext<<2i.
  - Then shift the window right by 2 (arithmetic) and increment i.
  - After the digit with i=N-1 is processed, go to ACC.
- State ACC, one edge:
  - C <= C + ext(P[2*REG_WIDTH-1:0]), where ext sign-extends if the latched signed_mode=1 and zero-extends otherwise.
  - The sum wraps modulo 2^ACC_WIDTH; no saturation, no overflow flag.
  - done<=1 for one cycle; go to IDLE.
- Timing: with the accept edge at E, C updates and done asserts after edge E+N+1. in_ready is high again in that same cycle. Peak throughput is one operation per N+2 cycles (7 for REG_WIDTH=8).
- acc_clear:
  - In any state other than the ACC edge: C<=0.
  - Coincident with the ACC edge: C <= ext(product) (clear-and-load), and done still pulses.
  - It never affects P or the FSM.
- a_out/b_out hold their value between accepts.
- fwd_valid and done are never high in the same cycle for a single operation.
- reset has priority over acc_clear and in_valid.

Test Plan:
1. REG_WIDTH=8, unsigned, A=255, B=255, accepted at edge 0 -> done high after edge 6, C=65025; fwd_valid high after edge 0 only, with a_out=255, b_out=255.
2. Signed: A=0x80 (-128), B=0x80 -> C=16384. Then A=3, B=0xFB (-5) -> C=16369 (0x3FF1).
3. Unsigned, A=0x80, B=0x02 -> C=256. Same operands in signed mode, after acc_clear -> C=2^24-256 (0xFFFF00, ACC_WIDTH=24).
4. in_valid held high with two operations (2x3, then 4x5) -> in_ready low for 6 cycles after each accept; second accept at edge 7; final C=26; exactly two done pulses.
5. Accumulate 10 first. Then assert acc_clear on the ACC edge of 7x7 -> C=49, not 59. acc_clear during IDLE -> C=0 on the next edge.
6. Reset asserted during MUL of 100x100 -> all outputs 0 on the next edge and no done. After release, 2x2 -> C=4.
7. ACC_WIDTH=16 override, unsigned 255x255 twice -> C=64514 (wrap-around).
